// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver and packer state
// encodings plus small width/lane helpers used by the word packer.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        PK_EMPTY,
        PK_COLLECT
    } pk_state_t;

    function automatic int word_width(input int n, input int word_bytes);
        return n * word_bytes;
    endfunction

    // Bit offset of byte lane k; lane 0 is the least-significant byte.
    function automatic int lane_lsb(input int k, input int n);
        return k * n;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Pointer-based synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             full;
    logic             pop_en;
    logic             push_en;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en  = pop_i && !empty_o && !clear_i;
    assign push_en = push_i && !clear_i && (!full || pop_en);
    assign drop_o  = push_i && !clear_i && !push_en;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            // NOTE: the storage array is reset on purpose so the head word reads 0 after reset; most FIFOs leave memories unreset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs one-cycle byte strobes LSB-first into words, queues them in a small
// FIFO and drops a stale partial word after an inter-byte timeout.
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int N              = 8,
    parameter int WORD_BYTES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int WORD_W        = word_width(N, WORD_BYTES),
    localparam int BC_W          = $clog2(WORD_BYTES) + 1,
    localparam int FC_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      byte_in,
    input  logic              byte_valid,
    input  logic              flush,
    input  logic              clear_overflow,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [BC_W-1:0]   byte_count,
    output logic [FC_W-1:0]   fifo_count,
    output logic              overflow,
    output logic              timeout
);

    localparam int LANE_W = WORD_W - N;
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WORD_BYTES - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    pk_state_t         state_q;
    logic [BC_W-1:0]   byte_count_q;
    logic [LANE_W-1:0] lanes_q;
    logic [TW-1:0]     tmo_cnt_q;
    logic              overflow_q;
    logic              timeout_q;

    logic last_byte;
    logic push;
    logic drop;
    logic expire;
    logic fifo_empty;

    // The final byte bypasses the lane register and goes straight into the FIFO.
    assign last_byte = (state_q == PK_COLLECT) && (byte_count_q == LAST_IDX);
    assign push      = byte_valid && !flush && last_byte;
    assign expire    = (TIMEOUT_CYCLES != 0) && (state_q == PK_COLLECT) &&
                       !byte_valid && (tmo_cnt_q == TMO_LAST);

    sync_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (word_ready),
        .wdata_i ({byte_in, lanes_q}),
        .rdata_o (word_out),
        .empty_o (fifo_empty),
        .drop_o  (drop),
        .count_o (fifo_count)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking to avoid read-order races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= PK_EMPTY;
            byte_count_q <= '0;
            lanes_q      <= '0;
            tmo_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (flush) begin
                state_q      <= PK_EMPTY;
                byte_count_q <= '0;
                lanes_q      <= '0;
                tmo_cnt_q    <= '0;
            end else begin
                unique case (state_q)
                    PK_EMPTY: begin
                        if (byte_valid) begin
                            lanes_q[lane_lsb(0, N) +: N] <= byte_in;
                            byte_count_q                 <= BC_W'(1);
                            tmo_cnt_q                    <= '0;
                            state_q                      <= PK_COLLECT;
                        end
                    end
                    PK_COLLECT: begin
                        if (byte_valid) begin
                            tmo_cnt_q <= '0;
                            if (last_byte) begin
                                lanes_q      <= '0;
                                byte_count_q <= '0;
                                state_q      <= PK_EMPTY;
                            end else begin
                                lanes_q[lane_lsb(int'(byte_count_q), N) +: N] <= byte_in;
                                byte_count_q <= byte_count_q + BC_W'(1);
                            end
                        end else if (expire) begin
                            lanes_q      <= '0;
                            byte_count_q <= '0;
                            tmo_cnt_q    <= '0;
                            timeout_q    <= 1'b1;
                            state_q      <= PK_EMPTY;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        end
                    end
                    default: state_q <= PK_EMPTY;
                endcase
            end

            // A drop in the same cycle as clear_overflow keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign word_valid = !fifo_empty;
    assign byte_count = byte_count_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: stimulus pushes expected words into a
// queue that a negedge monitor pops on every accepted output word.
module tb_uart_word_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        flush;
    logic        clear_overflow;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  byte_count;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        timeout;

    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    uart_word_packer #(
        .N              (8),
        .WORD_BYTES     (4),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .byte_count     (byte_count),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[k*8 +: 8]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_out"},   word_out,   32'h0);
        check({tag, "_word_valid"}, word_valid, 1'b0);
        check({tag, "_byte_count"}, byte_count, 3'd0);
        check({tag, "_fifo_count"}, fifo_count, 3'd0);
        check({tag, "_overflow"},   overflow,   1'b0);
        check({tag, "_timeout"},    timeout,    1'b0);
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h expected none", word_out);
            end else begin
                check("word_out", word_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        reset          = 1'b0;
        byte_in        = '0;
        byte_valid     = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        word_ready     = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        // Basic pack, consumer always ready.
        word_ready = 1'b1;
        exp_q.push_back(32'h12345678);
        send_word(32'h12345678);
        check("basic_valid_rise", word_valid, 1'b1);
        step();
        check("basic_valid_one_cycle", word_valid, 1'b0);

        // Backpressure: five words into a four-entry FIFO; the fifth drops
        // even though clear_overflow is raised in the same cycle.
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'(i));
            send_word(32'(i));
        end
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        byte_in        = 8'h00;
        byte_valid     = 1'b1;
        clear_overflow = 1'b1;
        step();
        byte_valid     = 1'b0;
        clear_overflow = 1'b0;
        check("ovf_fifo_count", fifo_count, 3'd4);
        check("ovf_flag",       overflow,   1'b1);
        check("ovf_byte_count", byte_count, 3'd0);
        check("ovf_head",       word_out,   32'h1);
        word_ready = 1'b1;
        step();
        step();
        word_ready = 1'b0;
        check("drain2_fifo_count", fifo_count, 3'd2);

        // Flush on the third byte with two words queued; overflow survives.
        send_byte(8'hEE);
        send_byte(8'hEF);
        byte_in    = 8'hF0;
        byte_valid = 1'b1;
        flush      = 1'b1;
        step();
        byte_valid = 1'b0;
        flush      = 1'b0;
        exp_q.delete();
        check("flush_fifo_count", fifo_count, 3'd0);
        check("flush_byte_count", byte_count, 3'd0);
        check("flush_word_valid", word_valid, 1'b0);
        check("flush_overflow",   overflow,   1'b1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("clear_overflow", overflow, 1'b0);
        word_ready = 1'b1;
        exp_q.push_back(32'h44332211);
        send_word(32'h44332211);
        step();
        check("post_flush_fifo_count", fifo_count, 3'd0);

        // Timeout after 100 idle cycles discards 0xAA,0xBB.
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("tmo_partial_count", byte_count, 3'd2);
        repeat (99) step();
        check("tmo_not_yet",       timeout,    1'b0);
        check("tmo_count_held",    byte_count, 3'd2);
        step();
        check("tmo_pulse",         timeout,    1'b1);
        check("tmo_byte_count",    byte_count, 3'd0);
        step();
        check("tmo_pulse_end",     timeout,    1'b0);
        exp_q.push_back(32'h04030201);
        send_word(32'h04030201);
        step();

        // A byte arriving exactly in the expiry cycle wins over the timeout.
        send_byte(8'hAA);
        repeat (99) step();
        send_byte(8'hBB);
        check("race_no_timeout",  timeout,    1'b0);
        check("race_byte_count",  byte_count, 3'd2);
        step();
        check("race_no_late_pulse", timeout,  1'b0);
        exp_q.push_back(32'hDDCCBBAA);
        send_byte(8'hCC);
        send_byte(8'hDD);
        step();

        // Full FIFO: the final byte arrives with a pop in the same cycle.
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA0A0A0A0 + 32'(i);
            exp_q.push_back(w);
            send_word(w);
        end
        check("full_fifo_count", fifo_count, 3'd4);
        exp_q.push_back(32'hB4B3B2B1);
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        byte_in    = 8'hB4;
        byte_valid = 1'b1;
        word_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        check("full_pop_fifo_count", fifo_count, 3'd4);
        check("full_pop_overflow",   overflow,   1'b0);
        repeat (4) step();
        check("full_drained_valid",  word_valid, 1'b0);
        check("full_drained_count",  fifo_count, 3'd0);

        // Reset mid-word with one word queued discards everything.
        word_ready = 1'b0;
        exp_q.push_back(32'hC0C0C0C0);
        send_word(32'hC0C0C0C0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("pre_reset_fifo_count", fifo_count, 3'd1);
        check("pre_reset_byte_count", byte_count, 3'd2);
        reset = 1'b0;
        step();
        exp_q.delete();
        check_reset_outputs("midreset");
        reset      = 1'b1;
        word_ready = 1'b1;
        exp_q.push_back(32'h87654321);
        send_word(32'h87654321);
        step();
        check("post_reset_byte_count", byte_count, 3'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Packs the byte stream produced by the UART receiver into 32-bit words for the instruction/data loader. Each one-cycle byte strobe from the receiver is packed least-significant-byte first. Completed words are queued in a small synchronous FIFO and drained over a valid/ready handshake. An inter-byte timeout discards partial words so a host resync never leaves the packer misaligned.

## Interface
- N, 8: bits per received byte (matches receiver data width)
- WORD_BYTES, 4: bytes per output word; WORD_W = N*WORD_BYTES
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1000000: clk cycles without a byte before a partial word is dropped; 0 disables the timeout
- clk  in  1  system clock
- reset  in  1  synchronous, active-low: reset==0 at a rising edge clears the block
- byte_in  in  N  received byte; sampled only when byte_valid=1
- byte_valid  in  1  one-cycle strobe, receiver `valid`
- flush  in  1  synchronous clear of partial word and FIFO
- clear_overflow  in  1  clears sticky overflow
- word_out  out  WORD_W  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts head when word_valid & word_ready
- byte_count  out  clog2(WORD_BYTES)+1  bytes held in the partial word
- fifo_count  out  clog2(FIFO_DEPTH)+1  words queued
- overflow  out  1  sticky: a completed word was dropped
- timeout  out  1  one-cycle pulse: partial word discarded

## Operation
- Partial-word FSM: EMPTY (byte_count==0) and COLLECT (byte_count 1..WORD_BYTES-1).
- EMPTY --byte_valid--> COLLECT. COLLECT --final byte--> EMPTY. COLLECT --timeout/flush--> EMPTY.
- Lane placement: the k-th byte (k = 0..WORD_BYTES-1) lands in bits [k*N +: N]. Byte 0 is the LSB.
- Word completion: byte_valid with byte_count==WORD_BYTES-1 writes the word {byte_in, held lanes} straight into the FIFO at that edge. byte_count returns to 0.
- Push acceptance: accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Overflow: if a push is refused, the word is dropped, overflow is set and byte_count still returns to 0.
- Pop: occurs when word_valid & word_ready. Pop while empty is ignored.
- Simultaneous push and pop: fifo_count is unchanged.
- Timeout counter: active only in COLLECT. Reset to 0 on every byte_valid; increments otherwise.
- Timeout expiry: when the counter reaches TIMEOUT_CYCLES-1 with no byte_valid that cycle:
  - partial lanes cleared, byte_count=0
  - timeout=1 for the following cycle
- byte_valid in the expiry cycle: the byte wins and no timeout occurs.
- flush: has priority over everything except reset.
  - Clears partial word, byte_count, FIFO pointers and timeout counter.
  - A byte_valid in the same cycle is discarded.
  - overflow is not affected by flush.
- clear_overflow: clears overflow. A drop in the same cycle wins, so overflow stays 1.
- word_out: equals mem[rd_ptr], first-word fall-through. When the FIFO is empty, word_out holds the stale entry; consumers must qualify it with word_valid.

## Timing
- Reset values: word_out=0 (all FIFO entries cleared), word_valid=0, byte_count=0, fifo_count=0, overflow=0, timeout=0. FSM=EMPTY, timeout counter=0.
- Latency: final byte_valid at cycle t → word_valid=1 and word_out correct at t+1.
- Pop at edge t → next entry (or word_valid=0) visible at t+1.
- byte_count and fifo_count are registered and update at the edge following the event.
- Reset asserted mid-word or mid-drain discards everything; the first byte after reset release is lane 0.
- Back-to-back byte_valid on consecutive cycles is supported, although the UART never produces it.

## Structure
- Shared package (uart_pkg): packer FSM state encoding, WORD_W derivation, byte-lane index helper. The receiver's states also move into this package.
- Sub-module sync_word_fifo (WIDTH, DEPTH): pointer-based, full/empty from an extra pointer bit, push-while-full-with-pop allowed, outputs count.
- Top module: FSM, lane register, timeout counter, overflow flag.

## Test plan
- Basic pack: bytes 0x78,0x56,0x34,0x12 with word_ready=1 → word_out=0x12345678, word_valid high for exactly 1 cycle, one cycle after the 4th strobe.
- Backpressure and overflow: word_ready=0, FIFO_DEPTH=4, push 5 words (0x00000001..0x00000005) → fifo_count=4, overflow=1. Draining yields words 1..4 in order, and word 5 is lost.
- Timeout: TIMEOUT_CYCLES=100, send 0xAA,0xBB, then idle 100 cycles → timeout pulse, byte_count=0. Then 0x01,0x02,0x03,0x04 → 0x04030201.
- Expiry race: byte_valid exactly in the expiry cycle → no timeout pulse, byte_count increments.
- Full with pop: FIFO full, final byte with word_ready=1 in the same cycle → push accepted, fifo_count stays 4, overflow=0.
- Flush and reset: flush during byte 3 of a word with 2 words queued → fifo_count=0, byte_count=0, overflow unchanged. reset=0 mid-word → all outputs at reset values.
